// File: rtl/uart_core.sv
// UART core: TX and RX engines with independent first-word fall-through FIFOs.
// Frame format (5..DATA_W data bits, optional parity, 1 or 2 stops) is latched per frame.
module uart_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_cfg_cpb,
  input  logic [3:0]        i_cfg_nbits,
  input  logic [1:0]        i_cfg_parity,
  input  logic              i_cfg_stop,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic [1:0]        o_rx_err,
  output logic              o_rx_overrun,
  output logic              o_tx_busy,
  output logic              o_tx_serial,
  input  logic              i_rx_serial
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         RXW       = DATA_W + 2;
  localparam logic [3:0] NBITS_MAX = 4'(DATA_W);

  function automatic logic [3:0] effNbits(input logic [3:0] n);
    if (n < 4'd5 || n > NBITS_MAX) return NBITS_MAX;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] bitMask(input logic [3:0] n);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (4'(i) < n);
    return m;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] r_txMem [FIFO_DEPTH];
  logic [AW:0]       r_txWrPtr, r_txRdPtr;
  logic              w_txFull, w_txEmpty, w_txPush, w_txPop;

  assign w_txEmpty  = (r_txWrPtr == r_txRdPtr);
  assign w_txFull   = (r_txWrPtr[AW] != r_txRdPtr[AW]) &&
                      (r_txWrPtr[AW-1:0] == r_txRdPtr[AW-1:0]);
  assign o_tx_ready = !w_txFull;
  assign w_txPush   = i_tx_valid && !w_txFull;

  always_ff @(posedge i_clk) begin
    if (w_txPush) r_txMem[r_txWrPtr[AW-1:0]] <= i_tx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txWrPtr <= '0;
      r_txRdPtr <= '0;
    end else begin
      if (w_txPush) r_txWrPtr <= r_txWrPtr + 1'b1;
      if (w_txPop)  r_txRdPtr <= r_txRdPtr + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  txState_t          r_txState, w_txNext;
  logic [15:0]       r_txCell, r_txCpb;
  logic [3:0]        r_txBitIdx, r_txNbits;
  logic              r_txParEn, r_txParBit, r_txTwoStop, r_txStopIdx, r_txSerial;
  logic [DATA_W-1:0] r_txShift;
  logic              w_txCellEnd, w_txBit;
  logic [3:0]        w_txLoadNbits;
  logic [DATA_W-1:0] w_txLoadData;

  assign w_txCellEnd   = (r_txCell == r_txCpb - 16'd1);
  assign w_txLoadNbits = effNbits(i_cfg_nbits);
  assign w_txLoadData  = r_txMem[r_txRdPtr[AW-1:0]] & bitMask(w_txLoadNbits);
  // A word is taken from the FIFO whenever a new frame begins, from IDLE or straight out of STOP.
  assign w_txPop       = (w_txNext == TX_START) && (r_txState != TX_START);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_txState <= TX_IDLE;
    else          r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE:   if (!w_txEmpty) w_txNext = TX_START;
      TX_START:  if (w_txCellEnd) w_txNext = TX_DATA;
      TX_DATA:   if (w_txCellEnd && r_txBitIdx == r_txNbits - 4'd1)
                   w_txNext = r_txParEn ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_txCellEnd) w_txNext = TX_STOP;
      TX_STOP:   if (w_txCellEnd && r_txStopIdx == r_txTwoStop)
                   w_txNext = w_txEmpty ? TX_IDLE : TX_START;
      default:   w_txNext = TX_IDLE;
    endcase
  end

  always_comb begin
    w_txBit = 1'b1;
    case (r_txState)
      TX_START:  w_txBit = 1'b0;
      TX_DATA:   w_txBit = r_txShift[0];
      TX_PARITY: w_txBit = r_txParBit;
      default:   w_txBit = 1'b1;
    endcase
  end

  // The line is registered, which gives the two-edge latency from accept to start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txCell    <= '0;
      r_txCpb     <= '0;
      r_txBitIdx  <= '0;
      r_txNbits   <= '0;
      r_txParEn   <= 1'b0;
      r_txParBit  <= 1'b0;
      r_txTwoStop <= 1'b0;
      r_txStopIdx <= 1'b0;
      r_txShift   <= '0;
      r_txSerial  <= 1'b1;
    end else begin
      r_txSerial <= w_txBit;
      if (w_txPop) begin
        r_txCell    <= '0;
        r_txCpb     <= i_cfg_cpb;
        r_txBitIdx  <= '0;
        r_txNbits   <= w_txLoadNbits;
        r_txParEn   <= ^i_cfg_parity;
        r_txParBit  <= (^w_txLoadData) ^ i_cfg_parity[1];
        r_txTwoStop <= i_cfg_stop;
        r_txStopIdx <= 1'b0;
        r_txShift   <= w_txLoadData;
      end else if (r_txState == TX_IDLE) begin
        r_txCell <= '0;
      end else if (w_txCellEnd) begin
        r_txCell <= '0;
        if (r_txState == TX_DATA) begin
          r_txBitIdx <= r_txBitIdx + 4'd1;
          r_txShift  <= r_txShift >> 1;
        end
        if (r_txState == TX_STOP) r_txStopIdx <= 1'b1;
      end else begin
        r_txCell <= r_txCell + 16'd1;
      end
    end
  end

  assign o_tx_serial = r_txSerial;
  assign o_tx_busy   = (r_txState != TX_IDLE) || !w_txEmpty;

  // ---------------- RX synchronizer and FSM ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;
  rxState_t          r_rxState, w_rxNext;
  logic              r_rxSync1, r_rxSync2, w_rxIn;
  logic [15:0]       r_rxCnt, r_rxCpb;
  logic [3:0]        r_rxBitIdx, r_rxNbits;
  logic              r_rxParEn, r_rxParOdd, r_rxParErr;
  logic [DATA_W-1:0] r_rxShift;
  logic              w_rxStartSample, w_rxSample, w_rxPush;
  logic [RXW-1:0]    w_rxWord;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
    end else begin
      r_rxSync1 <= i_rx_serial;
      r_rxSync2 <= r_rxSync1;
    end
  end

  assign w_rxIn          = r_rxSync2;
  assign w_rxStartSample = (r_rxCnt == (r_rxCpb >> 1) - 16'd1);
  assign w_rxSample      = (r_rxCnt == r_rxCpb - 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rxState <= RX_IDLE;
    else          r_rxState <= w_rxNext;
  end

  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE:      if (!w_rxIn) w_rxNext = RX_START;
      RX_START:     if (w_rxStartSample) w_rxNext = w_rxIn ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_rxSample && r_rxBitIdx == r_rxNbits - 4'd1)
                      w_rxNext = r_rxParEn ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (w_rxSample) w_rxNext = RX_STOP;
      RX_STOP:      if (w_rxSample) w_rxNext = w_rxIn ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (w_rxIn) w_rxNext = RX_IDLE;
      default:      w_rxNext = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rxPush = (r_rxState == RX_STOP) && w_rxSample;
    w_rxWord = {r_rxParErr, !w_rxIn, r_rxShift};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxCnt    <= '0;
      r_rxCpb    <= '0;
      r_rxBitIdx <= '0;
      r_rxNbits  <= '0;
      r_rxParEn  <= 1'b0;
      r_rxParOdd <= 1'b0;
      r_rxParErr <= 1'b0;
      r_rxShift  <= '0;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          r_rxCnt <= '0;
          if (!w_rxIn) begin
            r_rxCpb    <= i_cfg_cpb;
            r_rxNbits  <= effNbits(i_cfg_nbits);
            r_rxParEn  <= ^i_cfg_parity;
            r_rxParOdd <= (i_cfg_parity == 2'b10);
            r_rxBitIdx <= '0;
            r_rxParErr <= 1'b0;
            r_rxShift  <= '0;
          end
        end
        RX_START: r_rxCnt <= w_rxStartSample ? 16'd0 : r_rxCnt + 16'd1;
        RX_DATA: begin
          if (w_rxSample) begin
            r_rxCnt    <= '0;
            r_rxBitIdx <= r_rxBitIdx + 4'd1;
            for (int i = 0; i < DATA_W; i++)
              if (4'(i) == r_rxBitIdx) r_rxShift[i] <= w_rxIn;
          end else begin
            r_rxCnt <= r_rxCnt + 16'd1;
          end
        end
        RX_PARITY: begin
          if (w_rxSample) begin
            r_rxCnt    <= '0;
            r_rxParErr <= w_rxIn != ((^r_rxShift) ^ r_rxParOdd);
          end else begin
            r_rxCnt <= r_rxCnt + 16'd1;
          end
        end
        RX_STOP: r_rxCnt <= w_rxSample ? 16'd0 : r_rxCnt + 16'd1;
        default: r_rxCnt <= '0;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RXW-1:0] r_rxMem [FIFO_DEPTH];
  logic [AW:0]    r_rxWrPtr, r_rxRdPtr;
  logic           w_rxFull, w_rxEmpty, w_rxPop, w_rxWrite;
  logic           r_rxOverrun;
  logic [RXW-1:0] w_rxHead;

  assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
  assign w_rxFull  = (r_rxWrPtr[AW] != r_rxRdPtr[AW]) &&
                     (r_rxWrPtr[AW-1:0] == r_rxRdPtr[AW-1:0]);
  assign w_rxPop   = !w_rxEmpty && i_rx_ready;
  // At full, a same-cycle pop frees the slot being written, so both proceed.
  assign w_rxWrite = w_rxPush && (!w_rxFull || w_rxPop);

  always_ff @(posedge i_clk) begin
    if (w_rxWrite) r_rxMem[r_rxWrPtr[AW-1:0]] <= w_rxWord;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxWrPtr   <= '0;
      r_rxRdPtr   <= '0;
      r_rxOverrun <= 1'b0;
    end else begin
      if (w_rxWrite) r_rxWrPtr <= r_rxWrPtr + 1'b1;
      if (w_rxPop)   r_rxRdPtr <= r_rxRdPtr + 1'b1;
      r_rxOverrun <= w_rxPush && w_rxFull && !w_rxPop;
    end
  end

  assign w_rxHead     = r_rxMem[r_rxRdPtr[AW-1:0]];
  assign o_rx_valid   = !w_rxEmpty;
  assign o_rx_data    = w_rxEmpty ? '0 : w_rxHead[DATA_W-1:0];
  assign o_rx_err     = w_rxEmpty ? 2'b00 : w_rxHead[RXW-1:DATA_W];
  assign o_rx_overrun = r_rxOverrun;

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: maximum data bits per frame, legal 5..9.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8: entries in each of the TX and RX FIFOs, a power of two and at least 2.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  single clock, rising edge.
REQ-004 SHALL have: rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have: cfg_cpb  input  16  clocks per bit, legal values 4 or more.
REQ-006 SHALL have: cfg_nbits  input  4  data bits per frame, 5..DATA_W; out-of-range values are treated as DATA_W.
REQ-007 SHALL have: cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have: cfg_stop  input  1  0 one stop bit, 1 two stop bits.
REQ-009 SHALL have: tx_data  input  DATA_W  byte to send; tx_valid  input  1; tx_ready  output  1  TX FIFO not full.
REQ-010 SHALL have: rx_data  output  DATA_W  RX FIFO head; rx_valid  output  1  RX FIFO not empty; rx_ready  input  1  pop.
REQ-011 SHALL have: rx_err  output  2  {parity_err, frame_err} of the head entry, aligned with rx_data.
REQ-012 SHALL have: rx_overrun  output  1  one-cycle pulse; tx_busy  output  1  frame in progress or TX FIFO non-empty.
REQ-013 SHALL have: tx_serial  output  1  serial line out; rx_serial  input  1  asynchronous serial line in.

Function
REQ-014 SHALL accept a TX word on clk when tx_valid&&tx_ready, and pop RX on clk when rx_valid&&rx_ready; both FIFOs are first-word fall-through.
REQ-015 SHALL latch cfg_* at each frame start for TX and RX independently; mid-frame cfg changes SHALL NOT affect the current frame.
REQ-016 SHALL hold every bit cell exactly cfg_cpb clocks, using a cell counter 0..cfg_cpb-1.
REQ-017 TX FSM SHALL follow IDLE->START->DATA->PARITY (skipped when none)->STOP (1 or 2 cells)->IDLE, or ->START directly if the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-018 TX SHALL send data LSB first using only bits [cfg_nbits-1:0]; the parity bit SHALL be the XOR over those bits (even), or its inverse (odd).
REQ-019 With TX idle, a word accepted at edge N SHALL drive tx_serial low starting at edge N+2.
REQ-020 RX SHALL pass rx_serial through a 2-flop synchronizer; all RX sampling uses the synchronized signal.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; IDLE->START on a low level.
REQ-022 START SHALL re-sample at cfg_cpb/2 (floor) clocks; if the line is high, the FSM SHALL return to IDLE (glitch rejected), otherwise it proceeds.
REQ-023 DATA, PARITY and STOP SHALL each sample once at the cell center, cfg_cpb clocks after the previous sample; data is assembled LSB first and bits above cfg_nbits are zero-filled.
REQ-024 parity_err SHALL be set when the received parity mismatches; frame_err SHALL be set when the first stop sample is 0; a second stop bit is not checked.
REQ-025 On the stop sample, RX SHALL push {errs,data} to the RX FIFO; if frame_err is set it SHALL go to WAIT_HIGH (until line is 1), otherwise to IDLE.
REQ-026 On a push with the RX FIFO full and no same-cycle pop, RX SHALL drop the word and pulse rx_overrun for one cycle; when a pop and a push fall in the same cycle at full, both SHALL succeed.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap; full when MSBs differ and the rest are equal; empty when the pointers are equal.

Reset
REQ-028 On rst low, asynchronously: tx_serial=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_err=00, rx_overrun=0, both FIFOs empty, both FSMs IDLE, all counters 0.
REQ-029 A reset mid-frame SHALL abort the frame with tx_serial high immediately; FIFO contents are discarded.

Verification
REQ-030 Scenario: cfg_cpb=16, 8N1, send 0xA5 -> tx_serial shows 0,1,0,1,0,0,1,0,1,1, each held 16 clocks; frame is 160 clocks; tx_busy then falls.
REQ-031 Scenario: loopback tx->rx, cfg_nbits=7, even parity, 2 stop bits, send 0x35 -> parity bit 0; rx_data=0x35, rx_err=00.
REQ-032 Scenario: drive an 8E1 frame of 0x01 with parity bit 0 -> rx_err=10; then a frame with stop bit 0 held low for 40 cells -> rx_err=01, exactly one entry, no further frames until the line goes high.
REQ-033 Scenario: FIFO_DEPTH=8, rx_ready=0, 9 loopback frames -> 8 entries, rx_overrun pulses once at the 9th stop sample, and popping yields frames 1..8 in order.
REQ-034 Scenario: cfg_cpb=16, 3-clock low glitch on rx_serial -> no push; reset asserted at data bit 4 of a TX frame -> tx_serial=1 at once, tx_ready=1.
